// File: rtl/mcdf_pkg.sv
// mcdf_pkg: shared types and helpers for the MCDF register block, arbiter and formatter
//
// Contents:
//   prio_t       2-bit channel priority, 0 = highest
//   len_t        3-bit packet length code
//   id_t         2-bit channel id
//   arb_state_e  arbiter FSM states {IDLE, XFER}
//   MAX_LEN_CODE largest length code that still doubles the packet size
//   last_beat()  index of the final beat for a length code (beats - 1)
package mcdf_pkg;

    typedef logic [1:0] prio_t;
    typedef logic [2:0] len_t;
    typedef logic [1:0] id_t;

    typedef enum logic {IDLE, XFER} arb_state_e;

    localparam int MAX_LEN_CODE = 5;

    // Beats are 1 << min(len, 5); codes above 5 saturate at 32 words.
    function automatic logic [4:0] last_beat(input len_t len);
        return (int'(len) > MAX_LEN_CODE) ? 5'd31 : 5'((6'd1 << len) - 6'd1);
    endfunction

endpackage

// File: rtl/mcdf_arb_select.sv
// mcdf_arb_select: combinational winner selection among the three slave channels
//
// Ports:
//   cand     in   3    candidate vector (enabled and requesting)
//   prio     in   3x2  per-channel priority, 0 = highest
//   last_id  in   2    previously served channel (only with MCDF_ARB_RR_EN)
//   win_id   out  2    winning channel
//   found    out  1    at least one candidate exists
//
// Macro MCDF_ARB_RR_EN: when defined, priority ties are broken round-robin
// starting after last_id; otherwise the lowest channel index wins a tie.
module mcdf_arb_select
    import mcdf_pkg::*;
(
    input  logic        [2:0] cand,
    input  prio_t       [2:0] prio,
`ifdef MCDF_ARB_RR_EN
    input  id_t               last_id,
`endif
    output id_t               win_id,
    output logic              found
);

    prio_t best;
    id_t   start;
    int    n;

    assign found = |cand;

    always_comb begin
        best   = 2'd3;
        win_id = 2'd0;
        n      = 0;
        for (int i = 0; i < 3; i++)
            best = (cand[i] && prio[i] < best) ? prio[i] : best;
`ifdef MCDF_ARB_RR_EN
        start = (last_id == 2'd2) ? 2'd0 : last_id + 2'd1;
`else
        start = 2'd0;
`endif
        // Walk the search order backwards so the earliest tied channel wins.
        for (int k = 2; k >= 0; k--) begin
            n      = (int'(start) + k) % 3;
            win_id = (cand[n] && prio[n] == best) ? id_t'(n) : win_id;
        end
    end

endmodule

// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: grants one of three slave channels per packet and streams it to the formatter
//
// Ports:
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   slvN_req_i  (N=0..2)      slave N holds at least one full packet
//   slvN_val_i / slvN_data_i  slave N data word and its valid
//   slvN_en_i                 channel enable from the control registers
//   slvN_prio_i               channel priority, 0 = highest
//   slvN_len_i                packet length code (beats = 1 << min(len,5))
//   a2sN_ack_o                word accepted from slave N (combinational)
//   f2a_id_req_i              formatter ready for a new packet
//   f2a_ack_i                 formatter accepts the current word
//   a2f_val_o / a2f_data_o    word and valid to the formatter
//   a2f_id_o / a2f_pkglen_o   granted channel and its latched length code
//   a2f_eop_o                 current word is the last of the packet
//
// Macro MCDF_ARB_RR_EN: round-robin tie-break between equal priorities
// (default build uses fixed lowest-index tie-break and has no last_id).
module mcdf_arbiter
    import mcdf_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          slv0_req_i,
    input  logic          slv0_val_i,
    input  logic [DW-1:0] slv0_data_i,
    input  logic          slv0_en_i,
    input  prio_t         slv0_prio_i,
    input  len_t          slv0_len_i,
    input  logic          slv1_req_i,
    input  logic          slv1_val_i,
    input  logic [DW-1:0] slv1_data_i,
    input  logic          slv1_en_i,
    input  prio_t         slv1_prio_i,
    input  len_t          slv1_len_i,
    input  logic          slv2_req_i,
    input  logic          slv2_val_i,
    input  logic [DW-1:0] slv2_data_i,
    input  logic          slv2_en_i,
    input  prio_t         slv2_prio_i,
    input  len_t          slv2_len_i,
    output logic          a2s0_ack_o,
    output logic          a2s1_ack_o,
    output logic          a2s2_ack_o,
    input  logic          f2a_id_req_i,
    input  logic          f2a_ack_i,
    output logic          a2f_val_o,
    output logic [DW-1:0] a2f_data_o,
    output id_t           a2f_id_o,
    output len_t          a2f_pkglen_o,
    output logic          a2f_eop_o
);

    arb_state_e    state;
    id_t           id;
    id_t           win_id;
    len_t          pkglen;
    len_t          win_len;
    logic [4:0]    cnt;
    logic          found;
    logic          xfer;
    logic          beat;
    logic          val_sel;
    logic [DW-1:0] data_sel;
`ifdef MCDF_ARB_RR_EN
    id_t           last_id;
`endif

    mcdf_arb_select u_sel (
        .cand    ({slv2_en_i & slv2_req_i, slv1_en_i & slv1_req_i, slv0_en_i & slv0_req_i}),
        .prio    ({slv2_prio_i, slv1_prio_i, slv0_prio_i}),
`ifdef MCDF_ARB_RR_EN
        .last_id (last_id),
`endif
        .win_id  (win_id),
        .found   (found)
    );

    always_comb begin
        val_sel  = (id == 2'd0) ? slv0_val_i  : (id == 2'd1) ? slv1_val_i  : slv2_val_i;
        data_sel = (id == 2'd0) ? slv0_data_i : (id == 2'd1) ? slv1_data_i : slv2_data_i;
        win_len  = (win_id == 2'd0) ? slv0_len_i : (win_id == 2'd1) ? slv1_len_i : slv2_len_i;
    end

    // All handshake outputs are gated by the state, so an asynchronous reset
    // clears them immediately without waiting for a clock edge.
    assign xfer         = (state == XFER);
    assign a2f_val_o    = xfer & val_sel;
    assign a2f_data_o   = xfer ? data_sel : '0;
    assign beat         = a2f_val_o & f2a_ack_i;
    assign a2f_eop_o    = a2f_val_o & (cnt == last_beat(pkglen));
    assign a2s0_ack_o   = xfer & (id == 2'd0) & f2a_ack_i & slv0_val_i;
    assign a2s1_ack_o   = xfer & (id == 2'd1) & f2a_ack_i & slv1_val_i;
    assign a2s2_ack_o   = xfer & (id == 2'd2) & f2a_ack_i & slv2_val_i;
    assign a2f_id_o     = id;
    assign a2f_pkglen_o = pkglen;

    // Grant, length and counter are latched at grant time, so register or
    // request changes during a packet cannot alter it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            id      <= '0;
            pkglen  <= '0;
            cnt     <= '0;
`ifdef MCDF_ARB_RR_EN
            last_id <= 2'd2;
`endif
        end else if (state == IDLE) begin
            if (f2a_id_req_i && found) begin
                state  <= XFER;
                id     <= win_id;
                pkglen <= win_len;
                cnt    <= '0;
            end
        end else if (beat) begin
            cnt <= cnt + 5'd1;
            if (a2f_eop_o) begin
                state   <= IDLE;
`ifdef MCDF_ARB_RR_EN
                last_id <= id;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// tb_mcdf_arbiter: directed self-checking bench for mcdf_arbiter
module tb_mcdf_arbiter;

    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          req [3];
    logic          val [3];
    logic          en  [3];
    logic [1:0]    prio[3];
    logic [2:0]    len [3];
    logic [DW-1:0] data[3];
    logic          f2a_id_req_i;
    logic          f2a_ack_i;
    logic          a2s0_ack_o, a2s1_ack_o, a2s2_ack_o;
    logic          a2f_val_o, a2f_eop_o;
    logic [DW-1:0] a2f_data_o;
    logic [1:0]    a2f_id_o;
    logic [2:0]    a2f_pkglen_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    mcdf_arbiter #(.DW(DW)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .slv0_req_i   (req[0]),
        .slv0_val_i   (val[0]),
        .slv0_data_i  (data[0]),
        .slv0_en_i    (en[0]),
        .slv0_prio_i  (prio[0]),
        .slv0_len_i   (len[0]),
        .slv1_req_i   (req[1]),
        .slv1_val_i   (val[1]),
        .slv1_data_i  (data[1]),
        .slv1_en_i    (en[1]),
        .slv1_prio_i  (prio[1]),
        .slv1_len_i   (len[1]),
        .slv2_req_i   (req[2]),
        .slv2_val_i   (val[2]),
        .slv2_data_i  (data[2]),
        .slv2_en_i    (en[2]),
        .slv2_prio_i  (prio[2]),
        .slv2_len_i   (len[2]),
        .a2s0_ack_o   (a2s0_ack_o),
        .a2s1_ack_o   (a2s1_ack_o),
        .a2s2_ack_o   (a2s2_ack_o),
        .f2a_id_req_i (f2a_id_req_i),
        .f2a_ack_i    (f2a_ack_i),
        .a2f_val_o    (a2f_val_o),
        .a2f_data_o   (a2f_data_o),
        .a2f_id_o     (a2f_id_o),
        .a2f_pkglen_o (a2f_pkglen_o),
        .a2f_eop_o    (a2f_eop_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one packet from an IDLE cycle: the first sampled cycle must be IDLE,
    // every later one XFER from channel exp_id until n beats are accepted.
    // tog toggles f2a_ack each cycle, stall holds the slave's val low for three
    // cycles starting at that cycle, chg drops en and len after beat 3.
    task automatic pkt(input string tag, input int exp_id, input int n, input logic [2:0] plen,
                       input bit tog, input int stall, input bit chg);
        int   beats = 0;
        int   cyc   = 0;
        int   vb = 0, eb = 0, ab = 0, db = 0;
        logic xv;
        logic [2:0] xa;
        while (beats < n && cyc < 400) begin
            if (tog) f2a_ack_i = cyc[0];
            if (stall >= 0) val[exp_id] = !(cyc >= stall && cyc < stall + 3);
            #1;
            xv = (cyc > 0) && val[exp_id];
            xa = (xv && f2a_ack_i) ? (3'b001 << exp_id) : 3'b000;
            if (a2f_val_o !== xv) vb++;
            if (a2f_eop_o !== (xv && beats == n - 1)) eb++;
            if ({a2s2_ack_o, a2s1_ack_o, a2s0_ack_o} !== xa) ab++;
            if (a2f_data_o !== ((cyc > 0) ? data[exp_id] : '0)) db++;
            if (xv && f2a_ack_i) beats++;
            if (chg && beats == 3) begin
                en[exp_id]  = 1'b0;
                len[exp_id] = 3'd0;
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk({tag, "_beats"}, beats, n);
        chk({tag, "_val"}, vb, 0);
        chk({tag, "_eop"}, eb, 0);
        chk({tag, "_ack"}, ab, 0);
        chk({tag, "_data"}, db, 0);
        chk({tag, "_id"}, a2f_id_o, exp_id);
        chk({tag, "_pkglen"}, a2f_pkglen_o, plen);
        chk({tag, "_idle"}, a2f_val_o, 0);
    endtask

    initial begin
        int e;
        for (int i = 0; i < 3; i++) begin
            req[i]  = 1'b0;
            val[i]  = 1'b1;
            en[i]   = 1'b0;
            prio[i] = 2'd0;
            len[i]  = 3'd0;
        end
        data[0] = 32'hC0DE_0A00;
        data[1] = 32'hC0DE_1B11;
        data[2] = 32'hC0DE_2C22;
        f2a_id_req_i = 1'b1;
        f2a_ack_i    = 1'b1;

        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_val", a2f_val_o, 0);
        chk("rst_eop", a2f_eop_o, 0);
        chk("rst_ack", {a2s2_ack_o, a2s1_ack_o, a2s0_ack_o}, 0);
        chk("rst_data", a2f_data_o, 0);
        chk("rst_id", a2f_id_o, 0);
        chk("rst_pkglen", a2f_pkglen_o, 0);
        rstn_i = 1'b1;

        // single channel: slv1, len 2 -> 4 beats
        en[1] = 1'b1; prio[1] = 2'd1; len[1] = 3'd2; req[1] = 1'b1;
        pkt("single", 1, 4, 3'd2, 1'b0, -1, 1'b0);
        req[1] = 1'b0; en[1] = 1'b0;

        // priority: slv2 (prio 0) beats slv0 (prio 3)
        en[0] = 1'b1; prio[0] = 2'd3; req[0] = 1'b1;
        en[2] = 1'b1; prio[2] = 2'd0; req[2] = 1'b1;
        pkt("prio_a", 2, 1, 3'd0, 1'b0, -1, 1'b0);
        req[2] = 1'b0;
        pkt("prio_b", 0, 1, 3'd0, 1'b0, -1, 1'b0);
        req[0] = 1'b0;

        // equal priorities, all requesting; last served channel so far is 0
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b1; prio[i] = 2'd1; len[i] = 3'd0; req[i] = 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
`ifdef MCDF_ARB_RR_EN
            e = (i + 1) % 3;
`else
            e = 0;
`endif
            pkt($sformatf("tie%0d", i), e, 1, 3'd0, 1'b0, -1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; en[i] = 1'b0;
        end

        // mid-packet config change: 8-beat packet on slv1, en/len dropped after beat 3
        en[1] = 1'b1; len[1] = 3'd3; req[1] = 1'b1;
        pkt("cfg", 1, 8, 3'd3, 1'b0, -1, 1'b1);
        req[1] = 1'b0; en[1] = 1'b0;

        // backpressure and saturation: len 7 -> 32 beats, ack toggles, val stall
        en[0] = 1'b1; len[0] = 3'd7; req[0] = 1'b1;
        pkt("bp", 0, 32, 3'd7, 1'b1, 20, 1'b0);
        req[0] = 1'b0; en[0] = 1'b0; val[0] = 1'b1; f2a_ack_i = 1'b1;

        // reset mid-packet: 16-beat packet on slv1, reset after beat 5
        en[1] = 1'b1; prio[1] = 2'd1; len[1] = 3'd4; req[1] = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        chk("pre_rst_val", a2f_val_o, 1);
        chk("pre_rst_ack1", a2s1_ack_o, 1);
        chk("pre_rst_eop", a2f_eop_o, 0);
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_val", a2f_val_o, 0);
        chk("mid_rst_ack", {a2s2_ack_o, a2s1_ack_o, a2s0_ack_o}, 0);
        chk("mid_rst_eop", a2f_eop_o, 0);
        chk("mid_rst_data", a2f_data_o, 0);
        chk("mid_rst_id", a2f_id_o, 0);
        chk("mid_rst_pkglen", a2f_pkglen_o, 0);
        #2;
        rstn_i = 1'b1;
        en[0] = 1'b1; prio[0] = 2'd1; len[0] = 3'd0; req[0] = 1'b1;
        len[1] = 3'd0;
        pkt("post_rst", 0, 1, 3'd0, 1'b0, -1, 1'b0);
        req[0] = 1'b0; req[1] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
